// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with a single outstanding transaction.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the LSU has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        s_req_valid,
  input  logic        s_req_ready,
  output logic [31:0] s_addr,
  output logic        s_wen,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_wmask,
  input  logic        s_resp_valid,
  output logic        s_resp_ready,
  input  logic [31:0] s_rdata,
  input  logic        s_err,
  output logic [1:0]  dbg_state
);

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // source holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t state;
  logic   owner_lsu;
  logic   any_req;
  logic   grant_lsu;
  logic   in_resp;

  assign any_req = ifu_req_valid | lsu_req_valid;

`ifdef ARB_RR_EN
  logic last_lsu;
  // On a tie the master that did not win last time gets the port.
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu);
`else
  assign grant_lsu = lsu_req_valid;
`endif

  assign ifu_req_ready = (state == IDLE) & ifu_req_valid & ~grant_lsu;
  assign lsu_req_ready = (state == IDLE) & grant_lsu;

  // Response channel is a combinational pass-through to the owning master only.
  assign in_resp        = (state == RESP);
  assign ifu_resp_valid = in_resp & ~owner_lsu & s_resp_valid;
  assign lsu_resp_valid = in_resp & owner_lsu & s_resp_valid;
  assign ifu_rdata      = (in_resp & ~owner_lsu) ? s_rdata : 32'd0;
  assign lsu_rdata      = (in_resp & owner_lsu) ? s_rdata : 32'd0;
  assign ifu_err        = in_resp & ~owner_lsu & s_err;
  assign lsu_err        = in_resp & owner_lsu & s_err;
  assign s_resp_ready   = in_resp & (owner_lsu ? lsu_resp_ready : ifu_resp_ready);
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_lsu   <= 1'b0;
      s_req_valid <= 1'b0;
      s_addr      <= 32'd0;
      s_wen       <= 1'b0;
      s_wdata     <= 32'd0;
      s_wmask     <= 8'd0;
`ifdef ARB_RR_EN
      last_lsu    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_lsu   <= grant_lsu;
            s_req_valid <= 1'b1;
            s_addr      <= grant_lsu ? lsu_addr : ifu_addr;
            s_wen       <= grant_lsu & lsu_wen;
            s_wdata     <= grant_lsu ? lsu_wdata : 32'd0;
            s_wmask     <= grant_lsu ? lsu_wmask : 8'd0;
`ifdef ARB_RR_EN
            last_lsu    <= grant_lsu;
`endif
            state       <= REQ;
          end
        end
        REQ: begin
          if (s_req_ready) begin
            s_req_valid <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (s_resp_valid & s_resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reactive master/slave drivers, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [7:0]  s_wmask;
  logic [1:0]  dbg_state;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_rdata(s_rdata), .s_err(s_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; logic lsu; } grant_t;
  typedef struct { int cyc; logic [31:0] addr; logic wen; logic [31:0] wdata; logic [7:0] wmask; } sreq_t;
  typedef struct { int cyc; logic lsu; logic [31:0] rdata; logic err; } resp_t;

  grant_t grant_log[$];
  sreq_t  sreq_log[$];
  resp_t  resp_log[$];

  task automatic clear_logs();
    grant_log.delete();
    sreq_log.delete();
    resp_log.delete();
  endtask

  // ---------------- stimulus knobs ----------------
  bit          dir_mode = 1'b1;
  int          ifu_todo = 0, lsu_todo = 0;
  int          p_req_ifu = 100, p_req_lsu = 100, p_rr = 100, p_sready = 100;
  int          rr_wait_ifu = 0, rr_wait_lsu = 0;
  int          s_stall_cfg = 0, s_delay_cfg = 0;
  logic        s_err_cfg = 1'b0;
  logic [31:0] s_rdata_cfg = 32'd0;
  logic [31:0] ifu_cfg_addr = 32'd0, lsu_cfg_addr = 32'd0, lsu_cfg_wdata = 32'd0;
  logic        lsu_cfg_wen = 1'b0;
  logic [7:0]  lsu_cfg_wmask = 8'd0;

  // ---------------- IFU driver ----------------
  initial begin
    logic hs, rwait, rhs;
    int   rcnt;
    ifu_req_valid = 1'b0; ifu_addr = 32'd0; ifu_resp_ready = 1'b0; rcnt = 0;
    forever begin
      @(negedge clk);
      hs    = ifu_req_valid & ifu_req_ready;
      rwait = ifu_resp_valid & ~ifu_resp_ready;
      rhs   = ifu_resp_valid & ifu_resp_ready;
      @(posedge clk); #1;
      if (!rst) begin
        ifu_req_valid = 1'b0; ifu_resp_ready = 1'b0; rcnt = 0;
      end else begin
        if (hs) ifu_req_valid = 1'b0;
        if (!ifu_req_valid && ifu_todo > 0 && $urandom_range(1, 100) <= p_req_ifu) begin
          ifu_req_valid = 1'b1;
          ifu_addr = dir_mode ? ifu_cfg_addr : $urandom;
          ifu_todo--;
        end
        if (rhs) rcnt = 0;
        else if (rwait) rcnt++;
        ifu_resp_ready = dir_mode ? (rcnt >= rr_wait_ifu) : ($urandom_range(1, 100) <= p_rr);
      end
    end
  end

  // ---------------- LSU driver ----------------
  initial begin
    logic hs, rwait, rhs;
    int   rcnt;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0;
    lsu_wmask = 8'd0; lsu_resp_ready = 1'b0; rcnt = 0;
    forever begin
      @(negedge clk);
      hs    = lsu_req_valid & lsu_req_ready;
      rwait = lsu_resp_valid & ~lsu_resp_ready;
      rhs   = lsu_resp_valid & lsu_resp_ready;
      @(posedge clk); #1;
      if (!rst) begin
        lsu_req_valid = 1'b0; lsu_resp_ready = 1'b0; rcnt = 0;
      end else begin
        if (hs) lsu_req_valid = 1'b0;
        if (!lsu_req_valid && lsu_todo > 0 && $urandom_range(1, 100) <= p_req_lsu) begin
          lsu_req_valid = 1'b1;
          lsu_addr  = dir_mode ? lsu_cfg_addr : $urandom;
          lsu_wen   = dir_mode ? lsu_cfg_wen : 1'($urandom_range(0, 1));
          lsu_wdata = dir_mode ? lsu_cfg_wdata : $urandom;
          lsu_wmask = dir_mode ? lsu_cfg_wmask : 8'($urandom_range(0, 255));
          lsu_todo--;
        end
        if (rhs) rcnt = 0;
        else if (rwait) rcnt++;
        lsu_resp_ready = dir_mode ? (rcnt >= rr_wait_lsu) : ($urandom_range(1, 100) <= p_rr);
      end
    end
  end

  // ---------------- slave driver ----------------
  initial begin
    logic        req_hs, resp_hs, pend, rsp_err;
    logic [31:0] rsp_rdata;
    int          dly, stall_cnt;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = 32'd0; s_err = 1'b0;
    pend = 1'b0; dly = 0; stall_cnt = 0; rsp_rdata = 32'd0; rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      req_hs  = s_req_valid & s_req_ready;
      resp_hs = s_resp_valid & s_resp_ready;
      if (s_req_valid && !s_req_ready) stall_cnt++;
      @(posedge clk); #1;
      if (!rst) begin
        pend = 1'b0; s_resp_valid = 1'b0; s_req_ready = 1'b0; stall_cnt = 0;
      end else begin
        if (resp_hs) begin
          s_resp_valid = 1'b0;
          pend = 1'b0;
        end
        if (req_hs) begin
          pend = 1'b1;
          stall_cnt = 0;
          dly = dir_mode ? s_delay_cfg : $urandom_range(0, 3);
        end
        if (pend && !s_resp_valid) begin
          if (dly == 0) begin
            s_resp_valid = 1'b1;
            rsp_rdata = dir_mode ? s_rdata_cfg : $urandom;
            rsp_err   = dir_mode ? s_err_cfg : ($urandom_range(0, 7) == 0);
          end else dly--;
        end
        s_req_ready = !pend && (dir_mode ? (stall_cnt >= s_stall_cfg)
                                         : ($urandom_range(1, 100) <= p_sready));
        if (s_resp_valid) begin
          s_rdata = rsp_rdata;
          s_err   = rsp_err;
        end else begin
          s_rdata = $urandom;
          s_err   = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- transaction model + compare ----------------
  logic        m_busy = 1'b0, m_sent = 1'b0, m_owner = 1'b0, m_last_lsu = 1'b1;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  logic        m_wen = 1'b0;
  logic [7:0]  m_wmask = 8'd0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    logic lsu_wins, grant, in_resp, e_srr, own_i, own_l;
    if (!rst) begin
      m_busy = 1'b0; m_sent = 1'b0; m_owner = 1'b0; m_last_lsu = 1'b1;
      m_addr = 32'd0; m_wen = 1'b0; m_wdata = 32'd0; m_wmask = 8'd0;
      exp_q.delete();
      chk("rst_ifu_req_ready", ifu_req_ready, 0);
      chk("rst_lsu_req_ready", lsu_req_ready, 0);
      chk("rst_s_req_valid", s_req_valid, 0);
      chk("rst_s_resp_ready", s_resp_ready, 0);
      chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
      chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_s_wdata", s_wdata, 0);
      chk("rst_s_wmask", s_wmask, 0);
      chk("rst_s_wen", s_wen, 0);
      chk("rst_ifu_rdata", ifu_rdata, 0);
      chk("rst_lsu_rdata", lsu_rdata, 0);
    end else begin
      lsu_wins = lsu_req_valid && (!ifu_req_valid || !RR || !m_last_lsu);
      grant    = !m_busy && (ifu_req_valid || lsu_req_valid);
      in_resp  = m_busy && m_sent;
      own_i    = in_resp && !m_owner;
      own_l    = in_resp && m_owner;
      e_srr    = in_resp && (m_owner ? lsu_resp_ready : ifu_resp_ready);

      chk("ifu_req_ready", ifu_req_ready, !m_busy && ifu_req_valid && !lsu_wins);
      chk("lsu_req_ready", lsu_req_ready, !m_busy && lsu_wins);
      chk("s_req_valid", s_req_valid, m_busy && !m_sent);
      chk("s_addr", s_addr, m_addr);
      chk("s_wen", s_wen, m_wen);
      chk("s_wdata", s_wdata, m_wdata);
      chk("s_wmask", s_wmask, m_wmask);
      chk("s_resp_ready", s_resp_ready, e_srr);
      chk("ifu_resp_valid", ifu_resp_valid, own_i && s_resp_valid);
      chk("lsu_resp_valid", lsu_resp_valid, own_l && s_resp_valid);
      chk("ifu_rdata", ifu_rdata, own_i ? s_rdata : 32'd0);
      chk("lsu_rdata", lsu_rdata, own_l ? s_rdata : 32'd0);
      chk("ifu_err", ifu_err, own_i && s_err);
      chk("lsu_err", lsu_err, own_l && s_err);

      if (ifu_req_valid && ifu_req_ready) grant_log.push_back('{cyc, 1'b0});
      if (lsu_req_valid && lsu_req_ready) grant_log.push_back('{cyc, 1'b1});
      if (s_req_valid && s_req_ready) sreq_log.push_back('{cyc, s_addr, s_wen, s_wdata, s_wmask});
      if (ifu_resp_valid && ifu_resp_ready) resp_log.push_back('{cyc, 1'b0, ifu_rdata, ifu_err});
      if (lsu_resp_valid && lsu_resp_ready) resp_log.push_back('{cyc, 1'b1, lsu_rdata, lsu_err});

      if (grant) begin
        m_busy     = 1'b1;
        m_sent     = 1'b0;
        m_owner    = lsu_wins;
        m_last_lsu = lsu_wins;
        m_addr     = lsu_wins ? lsu_addr : ifu_addr;
        m_wen      = lsu_wins && lsu_wen;
        m_wdata    = lsu_wins ? lsu_wdata : 32'd0;
        m_wmask    = lsu_wins ? lsu_wmask : 8'd0;
        exp_q.push_back(m_addr);
      end else if (m_busy && !m_sent) begin
        if (s_req_ready) begin
          m_sent = 1'b1;
          if (exp_q.size() > 0) chk("sb_slave_addr", s_addr, exp_q.pop_front());
        end
      end else if (in_resp && s_resp_valid && e_srr) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  task automatic wait_resp(input int n, input int bound, input string name);
    int i;
    i = 0;
    while (resp_log.size() < n && i < bound) begin
      @(posedge clk);
      i++;
    end
    #2;
    chk(name, resp_log.size(), n);
  endtask

  initial begin
    logic [3:0] exp_arb;
    int         n_lsu, n_ifu, i;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #2;

    // Arbitration under constant contention, starting from reset state.
    exp_arb = RR ? 4'b1010 : 4'b1111;
    clear_logs();
    ifu_cfg_addr = 32'h0000_0100;
    lsu_cfg_addr = 32'h0000_0200; lsu_cfg_wen = 1'b0; lsu_cfg_wdata = 32'd0; lsu_cfg_wmask = 8'd0;
    s_rdata_cfg = 32'h1111_2222;
    ifu_todo = 4; lsu_todo = 4;
    wait_resp(8, 200, "arb_done");
    chk("arb_grants", grant_log.size(), 8);
    if (grant_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("arb_grant%0d", k), grant_log[k].lsu, exp_arb[k]);
      chk("arb_turnaround", grant_log[1].cyc - grant_log[0].cyc, 3);
    end

    // Single IFU fetch with a zero-wait slave.
    clear_logs();
    ifu_cfg_addr = 32'h8000_0000; s_rdata_cfg = 32'h0000_0413; s_err_cfg = 1'b0;
    ifu_todo = 1;
    wait_resp(1, 50, "fetch_done");
    if (grant_log.size() > 0 && sreq_log.size() > 0 && resp_log.size() > 0) begin
      chk("fetch_grant_ifu", grant_log[0].lsu, 0);
      chk("fetch_sreq_lat", sreq_log[0].cyc - grant_log[0].cyc, 1);
      chk("fetch_s_addr", sreq_log[0].addr, 32'h8000_0000);
      chk("fetch_s_wen", sreq_log[0].wen, 0);
      chk("fetch_s_wmask", sreq_log[0].wmask, 0);
      chk("fetch_resp_lat", resp_log[0].cyc - sreq_log[0].cyc, 1);
      chk("fetch_resp_owner", resp_log[0].lsu, 0);
      chk("fetch_rdata", resp_log[0].rdata, 32'h0000_0413);
    end

    // LSU store.
    clear_logs();
    lsu_cfg_addr = 32'h8000_1000; lsu_cfg_wen = 1'b1;
    lsu_cfg_wdata = 32'hDEAD_BEEF; lsu_cfg_wmask = 8'h0f; s_rdata_cfg = 32'h1234_5678;
    lsu_todo = 1;
    wait_resp(1, 50, "store_done");
    if (sreq_log.size() > 0 && resp_log.size() > 0) begin
      chk("store_s_wen", sreq_log[0].wen, 1);
      chk("store_s_addr", sreq_log[0].addr, 32'h8000_1000);
      chk("store_s_wdata", sreq_log[0].wdata, 32'hDEAD_BEEF);
      chk("store_s_wmask", sreq_log[0].wmask, 8'h0f);
      chk("store_resp_owner", resp_log[0].lsu, 1);
      chk("store_rdata", resp_log[0].rdata, 32'h1234_5678);
    end

    // Slave stalls on both channels; IFU asks while the LSU transaction is in flight.
    clear_logs();
    s_stall_cfg = 3; rr_wait_lsu = 2; lsu_cfg_addr = 32'h8000_2000;
    lsu_todo = 1;
    i = 0;
    while (grant_log.size() < 1 && i < 50) begin
      @(posedge clk);
      i++;
    end
    #2 ifu_todo = 1; ifu_cfg_addr = 32'h8000_0004;
    wait_resp(2, 100, "stall_done");
    chk("stall_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2 && sreq_log.size() >= 1 && resp_log.size() >= 2) begin
      chk("stall_sreq_lat", sreq_log[0].cyc - grant_log[0].cyc, 4);
      chk("stall_resp_lat", resp_log[0].cyc - grant_log[0].cyc, 7);
      chk("stall_first_owner", resp_log[0].lsu, 1);
      chk("stall_next_grant", grant_log[1].cyc - resp_log[0].cyc, 1);
      chk("stall_second_owner", resp_log[1].lsu, 0);
    end
    s_stall_cfg = 0; rr_wait_lsu = 0;

    // Slave error on an IFU read, then a clean read.
    clear_logs();
    s_err_cfg = 1'b1; ifu_todo = 1;
    wait_resp(1, 50, "err_done");
    if (resp_log.size() > 0) chk("err_set", resp_log[0].err, 1);
    clear_logs();
    s_err_cfg = 1'b0; ifu_todo = 1;
    wait_resp(1, 50, "noerr_done");
    if (resp_log.size() > 0) chk("err_clear", resp_log[0].err, 0);

    // Reset while the response is being offered.
    clear_logs();
    rr_wait_ifu = 1000; ifu_cfg_addr = 32'h8000_0040; s_rdata_cfg = 32'h5555_AAAA;
    ifu_todo = 1;
    i = 0;
    while (sreq_log.size() < 1 && i < 50) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk); #2;
    chk("rst_pre_resp_valid", ifu_resp_valid, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_resp_valid", ifu_resp_valid, 0);
    chk("rst_async_s_resp_ready", s_resp_ready, 0);
    chk("rst_async_s_addr", s_addr, 0);
    chk("rst_async_ifu_rdata", ifu_rdata, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1; rr_wait_ifu = 0;
    @(posedge clk); #2;
    clear_logs();
    ifu_cfg_addr = 32'h8000_0080; s_rdata_cfg = 32'hCAFE_0001;
    ifu_todo = 1;
    wait_resp(1, 50, "post_rst_done");
    if (resp_log.size() > 0 && sreq_log.size() > 0) begin
      chk("post_rst_addr", sreq_log[0].addr, 32'h8000_0080);
      chk("post_rst_rdata", resp_log[0].rdata, 32'hCAFE_0001);
    end

    // Randomized traffic against the per-cycle model.
    clear_logs();
    dir_mode = 1'b0; p_req_ifu = 60; p_req_lsu = 50; p_rr = 70; p_sready = 60;
    ifu_todo = 150; lsu_todo = 150;
    wait_resp(300, 20000, "rand_done");
    n_lsu = 0; n_ifu = 0;
    foreach (resp_log[k]) if (resp_log[k].lsu) n_lsu++; else n_ifu++;
    chk("rand_lsu_resps", n_lsu, 150);
    chk("rand_ifu_resps", n_ifu, 150);
    chk("rand_grants", grant_log.size(), 300);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter that shares the single memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). It sits between the fetch/load-store units and the memory slave, accepts one request at a time, forwards it on the slave request channel and routes the slave response back to the owning master. Exactly one transaction is outstanding at any time.

## Interface
Parameters:
- none. Address and data are 32 bits, write mask is 8 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ifu_req_valid / ifu_req_ready  in / out  1 / 1  IFU request handshake.
- ifu_addr  in  32  IFU fetch address.
- ifu_resp_valid / ifu_resp_ready  out / in  1 / 1  IFU response handshake.
- ifu_rdata  out  32  fetched word; ifu_err  out  1  slave error.
- lsu_req_valid / lsu_req_ready  in / out  1 / 1  LSU request handshake.
- lsu_addr  in  32; lsu_wen  in  1 (1 = store); lsu_wdata  in  32; lsu_wmask  in  8.
- lsu_resp_valid / lsu_resp_ready  out / in  1 / 1  LSU response handshake.
- lsu_rdata  out  32; lsu_err  out  1.
- s_req_valid / s_req_ready  out / in  1 / 1  slave request handshake.
- s_addr  out  32; s_wen  out  1; s_wdata  out  32; s_wmask  out  8.
- s_resp_valid / s_resp_ready  in / out  1 / 1  slave response handshake.
- s_rdata  in  32; s_err  in  1.

## Operation
- FSM states: IDLE, REQ, RESP. Reset state IDLE.
- IDLE: if either *_req_valid is high, pick winner; winner's *_req_ready = 1 that cycle (combinational on its valid, nothing else); latch addr/wen/wdata/wmask and owner id into buffer; next state REQ. IFU requests latch wen = 0, wdata = 0, wmask = 0.
- REQ: s_req_valid = 1, s_* driven from buffer (stable until accepted). On s_req_ready -> RESP.
- RESP: owner's *_resp_valid = s_resp_valid, *_rdata = s_rdata, *_err = s_err (pass-through); s_resp_ready = owner's *_resp_ready. On s_resp_valid & s_resp_ready -> IDLE. Non-owner resp_valid stays 0.
- Outside RESP: s_resp_ready = 0, both *_resp_valid = 0; stray slave responses are not consumed.
- Outside IDLE: both *_req_ready = 0.
- Arbitration (default): fixed priority, LSU wins when both valid.
- Reset mid-transaction: return to IDLE immediately, buffer and owner discarded, no response delivered; slave is reset together with the arbiter.

## Timing
- Reset values: all *_req_ready, *_resp_valid, s_req_valid, s_resp_ready = 0; s_addr, s_wdata, s_wmask, s_wen, *_rdata, *_err = 0; FSM = IDLE.
- Request accepted in cycle N (IDLE) -> s_req_valid high from N+1.
- Slave accepts in cycle M -> owner response visible from M+1 (same cycle s_resp_valid arrives, combinational pass-through).
- Response handshake in cycle K -> back in IDLE at K+1; next grant earliest K+1. Minimum turnaround 3 cycles per transaction with zero-wait slave.
- Simultaneous IFU and LSU valid in IDLE: exactly one ready; loser's valid must be held (sources keep valid until ready).

## Configuration
- ARB_RR_EN defined: round-robin. A last-grant register (reset = LSU) records the owner of each grant; on a tie the master not granted last wins. Single requester always wins regardless.
- ARB_RR_EN undefined: fixed priority LSU > IFU; last-grant register not present.

## Test plan
- Single IFU fetch, addr 0x80000000, zero-wait slave returning 0x00000413 -> ifu_req_ready in cycle 0, s_req_valid with s_addr 0x80000000, s_wen 0 in cycle 1, ifu_resp_valid with ifu_rdata 0x00000413 in cycle 2, lsu_resp_valid stays 0.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0f -> slave sees s_wen 1, s_wdata 0xDEADBEEF, s_wmask 0x0f; response routed only to LSU.
- Both valid in IDLE for 4 transactions: without ARB_RR_EN grants L,L,L,L while LSU held valid; with ARB_RR_EN grants I,L,I,L.
- Slave stalls: s_req_ready low 3 cycles, then s_resp_valid held with lsu_resp_ready low 2 cycles -> s_* fields stable throughout, one response handshake only, no new grant until completion.
- s_err = 1 on IFU read -> ifu_err = 1 with ifu_resp_valid; next transaction s_err = 0 -> ifu_err = 0.
- rst asserted low while in RESP -> all outputs 0 asynchronously, FSM IDLE; after release, fresh IFU request served normally.
